dda_oscillator_core: RTL and testbench

- Parametrised Euler-integration DDA solving the damped spring-mass system:
  - dv1/dt = v2
  - dv2/dt = -(k/m)·v1 - (d/m)·v2
- Successor to the fixed-coefficient, free-running integrator pair. Adds:
  - runtime coefficients, time step and initial conditions
  - a start/stop run controller with a step budget
  - a step counter and a per-step output strobe
- Uses one shared signed multiplier, time-multiplexed by a small FSM.
- Sits behind the tile I/O wrapper, which drives the configuration and consumes v1/v2.

---
 rtl/dda_oscillator_core.sv | 164 ++++++++++++++++
 tb/tb_dda_oscillator_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dda_oscillator_core.sv
// Damped spring-mass Euler DDA with one shared multiplier; optional SAT_EN clamps every W-bit reduction.
// Latency: 3 cycles per step, first step_valid 3 cycles after start; no backpressure, start is ignored while busy.
module dda_oscillator_core #(
    parameter int W     = 27,
    parameter int FRAC  = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [W-1:0]     k_coef,
    input  logic [W-1:0]     d_coef,
    input  logic [W-1:0]     ic1,
    input  logic [W-1:0]     ic2,
    input  logic [3:0]       dt_shift,
    input  logic [CNT_W-1:0] n_steps,
    output logic [W-1:0]     v1,
    output logic [W-1:0]     v2,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             step_valid,
    output logic             done,
    output logic             sat_flag
);
    typedef enum logic [1:0] {IDLE, MULK, MULD, UPD} state_t;
    state_t state, state_nxt;

    logic signed [W-1:0]   v1_q, v2_q, k_q, d_q;
    logic [3:0]            dt_q;
    logic [CNT_W-1:0]      n_q, cnt_q, cnt_inc;
    logic                  stop_pend, last_step;
    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [W:0]     pk_q, pd_q, mul_res;
    logic signed [W+1:0]   f, f_sh;
    logic signed [W-1:0]   v2_sh, v1_nxt, v2_nxt;

    assign cnt_inc   = cnt_q + CNT_W'(1);
    // stop sampled live as well, so a stop in the UPD cycle still ends the run after this step
    assign last_step = ((n_q != '0) && (cnt_inc == n_q)) || stop_pend || stop;

    assign mul_a = (state == MULK) ? v1_q : v2_q;
    assign mul_b = (state == MULK) ? k_q  : d_q;
    assign prod  = mul_a * mul_b;

    assign f     = -((W+2)'(pk_q)) - (W+2)'(pd_q);
    assign f_sh  = f >>> dt_q;
    assign v2_sh = v2_q >>> dt_q;

`ifdef SAT_EN
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [2*W-1:0] prod_sh;
    logic signed [W:0]     sum1;
    logic signed [W+2:0]   sum2;
    logic                  ovf_p, ovf1, ovf2, sat_q;

    // a value fits in W bits when every bit above the W-bit sign agrees with it
    assign prod_sh = prod >>> FRAC;
    assign ovf_p   = !((&prod_sh[2*W-1:W-1]) || !(|prod_sh[2*W-1:W-1]));
    assign mul_res = ovf_p ? (W+1)'(prod_sh[2*W-1] ? S_MIN : S_MAX) : prod_sh[W:0];

    assign sum1   = (W+1)'(v1_q) + (W+1)'(v2_sh);
    assign ovf1   = (sum1[W] != sum1[W-1]);
    assign v1_nxt = ovf1 ? (sum1[W] ? S_MIN : S_MAX) : sum1[W-1:0];

    assign sum2   = (W+3)'(v2_q) + (W+3)'(f_sh);
    assign ovf2   = !((&sum2[W+2:W-1]) || !(|sum2[W+2:W-1]));
    assign v2_nxt = ovf2 ? (sum2[W+2] ? S_MIN : S_MAX) : sum2[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            sat_q <= 1'b0;
        end else if ((((state == MULK) || (state == MULD)) && ovf_p) ||
                     ((state == UPD) && (ovf1 || ovf2))) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_flag = sat_q;
`else
    assign mul_res  = (W+1)'(prod >>> FRAC);
    assign v1_nxt   = v1_q + v2_sh;
    assign v2_nxt   = W'(v2_q + f_sh);
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MULK;
            MULK:    state_nxt = MULD;
            MULD:    state_nxt = UPD;
            UPD:     state_nxt = last_step ? IDLE : MULK;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= '0;
            v2_q       <= '0;
            k_q        <= '0;
            d_q        <= '0;
            dt_q       <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            pk_q       <= '0;
            pd_q       <= '0;
            stop_pend  <= 1'b0;
            busy       <= 1'b0;
            step_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    v1_q      <= ic1;
                    v2_q      <= ic2;
                    k_q       <= k_coef;
                    d_q       <= d_coef;
                    dt_q      <= dt_shift;
                    n_q       <= n_steps;
                    cnt_q     <= '0;
                    stop_pend <= stop;
                    busy      <= 1'b1;
                end
                MULK: begin
                    pk_q      <= mul_res;
                    stop_pend <= stop_pend | stop;
                end
                MULD: begin
                    pd_q      <= mul_res;
                    stop_pend <= stop_pend | stop;
                end
                UPD: begin
                    v1_q       <= v1_nxt;
                    v2_q       <= v2_nxt;
                    cnt_q      <= cnt_inc;
                    step_valid <= 1'b1;
                    if (last_step) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        stop_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign v1       = v1_q;
    assign v2       = v2_q;
    assign step_cnt = cnt_q;
endmodule

// File: tb/tb_dda_oscillator_core.sv
// Directed bench for dda_oscillator_core with a fixed-point reference model for the long damped runs.
module tb_dda_oscillator_core;
    localparam int W     = 27;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [W-1:0]     k_coef = '0, d_coef = '0, ic1 = '0, ic2 = '0;
    logic [3:0]       dt_shift = '0;
    logic [CNT_W-1:0] n_steps = '0;
    logic [W-1:0]     v1, v2;
    logic [CNT_W-1:0] step_cnt;
    logic             busy, step_valid, done, sat_flag;

    int checks = 0;
    int errors = 0;
    longint ma, mb, mk, md;
    int mdt;

    always #5 clk = ~clk;

    dda_oscillator_core dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .k_coef(k_coef), .d_coef(d_coef), .ic1(ic1), .ic2(ic2),
        .dt_shift(dt_shift), .n_steps(n_steps),
        .v1(v1), .v2(v2), .step_cnt(step_cnt), .busy(busy),
        .step_valid(step_valid), .done(done), .sat_flag(sat_flag)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint x, input int bits);
        longint t;
        t = x <<< (64 - bits);
        return t >>> (64 - bits);
    endfunction

    function automatic longint red27(input longint x);
`ifdef SAT_EN
        if (x > 64'sd67108863)  return 64'sd67108863;
        if (x < -64'sd67108864) return -64'sd67108864;
        return x;
`else
        return sx(x, 27);
`endif
    endfunction

    function automatic logic [26:0] m27(input longint x);
        return x[26:0];
    endfunction

    task automatic mstep();
        longint p, pk, pd, f, na, nb;
        p = (ma * mk) >>> 20;
`ifdef SAT_EN
        pk = red27(p);
`else
        pk = sx(p, 28);
`endif
        p = (mb * md) >>> 20;
`ifdef SAT_EN
        pd = red27(p);
`else
        pd = sx(p, 28);
`endif
        f  = sx(-pk - pd, 29);
        na = red27(ma + (mb >>> mdt));
        nb = red27(mb + (f >>> mdt));
        ma = na;
        mb = nb;
    endtask

    task automatic cfg(input logic [26:0] k, input logic [26:0] d, input logic [26:0] a,
                       input logic [26:0] b, input logic [3:0] dt, input logic [15:0] n);
        k_coef = k; d_coef = d; ic1 = a; ic2 = b; dt_shift = dt; n_steps = n;
        mk = sx(longint'(k), 27); md = sx(longint'(d), 27);
        ma = sx(longint'(a), 27); mb = sx(longint'(b), 27);
        mdt = int'(dt);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // counts edges until step_valid, giving up after 20
    task automatic wait_step(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!step_valid && lat < 20);
    endtask

    initial begin
        int lat;
        int seen;

        // reset held across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {v1, v2, step_cnt}, 70'h0);
        check("rst_flags", {busy, step_valid, done, sat_flag}, 4'b0000);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_busy", busy, 1'b0);

        // constant velocity: v1 advances by 1/16 per step
        cfg(27'h0, 27'h0, 27'h0, 27'h0100000, 4'd4, 16'd3);
        do_start();
        check("cv_busy", busy, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            wait_step(lat);
            check("cv_lat", lat, 3);
            check("cv_v1", v1, 27'(j * 32'h10000));
            check("cv_v2", v2, 27'h0100000);
            check("cv_cnt", step_cnt, 16'(j));
            check("cv_done_busy", {done, busy}, (j == 3) ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        #1 check("cv_pulse_end", {done, step_valid, busy, step_cnt}, {3'b000, 16'd3});
        check("cv_hold_v1", v1, 27'h0030000);

        // saturation on the position update
        cfg(27'h0, 27'h0, 27'h3FFFFFF, 27'h0100000, 4'd0, 16'd1);
        do_start();
        wait_step(lat);
`ifdef SAT_EN
        check("sat_v1", v1, 27'h3FFFFFF);
        check("sat_flag", sat_flag, 1'b1);
`else
        check("sat_v1", v1, 27'h40FFFFF);
        check("sat_flag", sat_flag, 1'b0);
`endif
        check("sat_v2_done", {v2, done}, {27'h0100000, 1'b1});

        // spring kick: single step, v2 = -0.5
        cfg(27'h0100000, 27'h0, 27'h0100000, 27'h0, 4'd1, 16'd1);
        do_start();
        check("kick_satclr", sat_flag, 1'b0);
        wait_step(lat);
        check("kick_lat", lat, 3);
        check("kick_v1", v1, 27'h0100000);
        check("kick_v2", v2, 27'h7F80000);
        check("kick_done", {done, busy, step_cnt}, {2'b10, 16'd1});

        // start and stop together: exactly one step
        cfg(27'h0, 27'h0, 27'h0, 27'h0100000, 4'd4, 16'd0);
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
        wait_step(lat);
        check("ss_step", {lat[7:0], v1, done, step_cnt}, {8'd3, 27'h0010000, 1'b1, 16'd1});

        // damped free run against the model
        cfg(27'h0080000, 27'h0040000, 27'h0, 27'h0500000, 4'd9, 16'd0);
        do_start();
        for (int i = 1; i <= 1000; i++) begin
            wait_step(lat);
            mstep();
            check("damp_state", {v1, v2}, {m27(ma), m27(mb)});
            check("damp_lat_cnt", {lat[15:0], step_cnt, done}, {16'd3, i[15:0], 1'b0});
            if (i == 500) begin
                start = 1'b1;
                ic1 = 27'h1234567; ic2 = 27'h0; k_coef = 27'h7000000; dt_shift = 4'd0;
            end
            if (i == 501) begin
                start = 1'b0;
                check("damp_busy", busy, 1'b1);
            end
        end
        stop = 1'b1;
        wait_step(lat);
        stop = 1'b0;
        mstep();
        check("damp_last", {v1, v2}, {m27(ma), m27(mb)});
        check("damp_end", {done, busy, step_cnt}, {2'b10, 16'd1001});

        // stop raised during MULD of step 5
        cfg(27'h0080000, 27'h0040000, 27'h0, 27'h0500000, 4'd9, 16'd0);
        do_start();
        for (int i = 1; i <= 4; i++) begin
            wait_step(lat);
            mstep();
        end
        check("stp_s4", {done, step_cnt}, {1'b0, 16'd4});
        @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_step(lat);
        mstep();
        check("stp_lat", lat, 1);
        check("stp_end", {done, busy, step_cnt}, {2'b10, 16'd5});
        check("stp_state", {v1, v2}, {m27(ma), m27(mb)});
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (step_valid || busy) seen++;
        end
        check("stp_halted", seen, 0);

        // asynchronous reset in the middle of a run
        cfg(27'h0, 27'h0, 27'h0, 27'h0100000, 4'd4, 16'd0);
        do_start();
        wait_step(lat);
        wait_step(lat);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst_state", {v1, v2, step_cnt, busy, step_valid, done, sat_flag},
                 {27'h0, 27'h0, 16'h0, 4'b0000});
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (step_valid || busy) seen++;
        end
        check("arst_idle", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
